// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder_pkg : data-bus request/response types and responder states
// Rev 1.0
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_array : 64-bit word storage, byte-lane write port, registered read port
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       be,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] r_mem [DEPTH_WORDS];
  logic [63:0] r_rdata;

  // Storage has no reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) r_rdata <= r_mem[idx];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder : single-outstanding data-bus memory responder
// Optional extra wait states when DBUS_WAIT_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t      r_state;
  logic             r_busy;
  logic             r_data_ok;
  logic             r_is_read;
  logic             w_accept;
  logic             w_is_write;
  logic [IDX_W-1:0] w_idx;
  logic [63:0]      w_rdata;
  logic             w_unused;

  assign w_accept   = (r_state == IDLE) && dreq.valid;
  assign w_is_write = (dreq.strobe != 8'd0);
  assign w_idx      = dreq.addr[3 +: IDX_W];
  assign w_unused   = ^{dreq.size, dreq.addr[2:0], dreq.addr[63:3+IDX_W], 4'(WAIT_CYCLES)};

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (w_accept && w_is_write),
    .be   (dreq.strobe),
    .re   (w_accept && !w_is_write),
    .idx  (w_idx),
    .wdata(dreq.data),
    .rdata(w_rdata)
  );

`ifdef DBUS_WAIT_EN
  logic [3:0] r_wait_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_data_ok <= 1'b0;
      r_is_read <= 1'b0;
`ifdef DBUS_WAIT_EN
      r_wait_cnt <= 4'd0;
`endif
    end else begin
      r_data_ok <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dreq.valid) begin
            r_is_read <= !w_is_write;
            r_busy    <= 1'b1;
`ifdef DBUS_WAIT_EN
            r_state    <= WAIT;
            r_wait_cnt <= 4'(WAIT_CYCLES);
`else
            r_state   <= RESP;
            r_data_ok <= 1'b1;
`endif
          end
        end
`ifdef DBUS_WAIT_EN
        WAIT: begin
          if (r_wait_cnt == 4'd1) begin
            r_state    <= RESP;
            r_data_ok  <= 1'b1;
            r_wait_cnt <= 4'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
`endif
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read data is only exposed in the response cycle of a read.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = w_accept;
    dresp.data_ok = r_data_ok;
    dresp.data    = (r_data_ok && r_is_read) ? w_rdata : 64'd0;
  end

  assign busy = r_busy;

endmodule
`default_nettype wire
